// File: rtl/instr_encoder.sv
// RV32I field-level instruction assembler: packs requests into 32-bit words
// and streams them into instruction memory at consecutive word addresses.
module instr_encoder #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [2:0]            reqKind,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    output logic                  reqError,
    output logic                  imemWe,
    output logic [ADDR_WIDTH-1:0] imemAddr,
    output logic [31:0]           imemWdata,
    input  logic                  imemReady,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   wordCount
);

    localparam int unsigned CountWidth = ADDR_WIDTH + 1;
    localparam logic [CountWidth-1:0] Capacity = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                stateQ, stateD;
    logic                  weD;
    logic [ADDR_WIDTH-1:0] addrD;
    logic [31:0]           dataD;
    logic [CountWidth-1:0] countD;
    logic                  fullD;
    logic                  errD;
    logic [31:0]           encWord;
    logic                  kindValid;
    logic                  unusedImm;

    // High immediate bits are discarded by design; no range checking.
    assign unusedImm = ^imm[31:13];

    assign reqReady = (stateQ == IDLE) && !full && !clear;

    // Opcode selection and immediate scatter per instruction kind.
    always_comb begin
        encWord   = '0;
        kindValid = 1'b1;
        case (reqKind)
            3'd0: encWord = {funct7, rs2, rs1, funct3, rd, OpR};
            3'd1: encWord = {imm[11:0], rs1, funct3, rd, OpIAlu};
            3'd2: encWord = {imm[11:0], rs1, funct3, rd, OpLoad};
            3'd3: encWord = {imm[11:5], rs2, rs1, funct3, imm[4:0], OpStore};
            3'd4: begin
                encWord   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OpBranch};
                kindValid = !imm[0];
            end
            default: kindValid = 1'b0;
        endcase
    end

    // Next-state and registered-output values.
    always_comb begin
        stateD = stateQ;
        weD    = imemWe;
        addrD  = imemAddr;
        dataD  = imemWdata;
        countD = wordCount;
        fullD  = full;
        errD   = 1'b0;
        case (stateQ)
            IDLE: begin
                if (clear) begin
                    addrD  = '0;
                    countD = '0;
                    fullD  = 1'b0;
                end else if (reqValid && reqReady) begin
                    if (kindValid) begin
                        dataD  = encWord;
                        weD    = 1'b1;
                        stateD = WRITE;
                    end else begin
                        errD = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (imemReady) begin
                    weD    = 1'b0;
                    addrD  = imemAddr + ADDR_WIDTH'(1);
                    countD = wordCount + CountWidth'(1);
                    fullD  = (wordCount + CountWidth'(1)) == Capacity;
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= IDLE;
            imemWe    <= 1'b0;
            imemAddr  <= '0;
            imemWdata <= '0;
            wordCount <= '0;
            full      <= 1'b0;
            reqError  <= 1'b0;
        end else begin
            stateQ    <= stateD;
            imemWe    <= weD;
            imemAddr  <= addrD;
            imemWdata <= dataD;
            wordCount <= countD;
            full      <= fullD;
            reqError  <= errD;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding vector table plus hand-written
// handshake, stall, fill/clear and reset sequences on a 4-word memory.
module tb_instr_encoder;

    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          reqValid;
    logic          reqReady;
    logic [2:0]    reqKind;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [4:0]    rd, rs1, rs2;
    logic [31:0]   imm;
    logic          reqError;
    logic          imemWe;
    logic [AW-1:0] imemAddr;
    logic [31:0]   imemWdata;
    logic          imemReady;
    logic          full;
    logic [AW:0]   wordCount;

    int checks = 0;
    int errors = 0;

    instr_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .reqValid(reqValid), .reqReady(reqReady), .reqKind(reqKind),
        .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .reqError(reqError), .imemWe(imemWe), .imemAddr(imemAddr),
        .imemWdata(imemWdata), .imemReady(imemReady), .full(full),
        .wordCount(wordCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  kind;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        expErr;
        logic [31:0] expWord;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(string n, logic [2:0] k, logic [2:0] f3, logic [6:0] f7,
                                logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                                logic [31:0] im, logic e, logic [31:0] w);
        vec_t v;
        v.name = n; v.kind = k; v.f3 = f3; v.f7 = f7; v.rd = d; v.rs1 = s1;
        v.rs2 = s2; v.imm = im; v.expErr = e; v.expWord = w;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reqKind = v.kind; funct3 = v.f3; funct7 = v.f7;
        rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    endtask

    initial begin
        vecs[0]  = mk("r_add",     3'd0, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,        1'b0, 32'h002081B3);
        vecs[1]  = mk("r_sub",     3'd0, 3'd0, 7'h20, 5'd5, 5'd6, 5'd7, 32'd0,        1'b0, 32'h407302B3);
        vecs[2]  = mk("i_addi_m1", 3'd1, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF00293);
        vecs[3]  = mk("i_himask",  3'd1, 3'd0, 7'h7F, 5'd1, 5'd2, 5'd9, 32'h12345678, 1'b0, 32'h67810093);
        vecs[4]  = mk("load_lw",   3'd2, 3'd2, 7'h00, 5'd4, 5'd1, 5'd0, 32'd4,        1'b0, 32'h0040A203);
        vecs[5]  = mk("store_sw",  3'd3, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        1'b0, 32'h0020A423);
        vecs[6]  = mk("store_neg", 3'd3, 3'd2, 7'h00, 5'd0, 5'd4, 5'd3, 32'hFFFFFFEC, 1'b0, 32'hFE322623);
        vecs[7]  = mk("br_m4",     3'd4, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 32'hFE208EE3);
        vecs[8]  = mk("br_2048",   3'd4, 3'd1, 7'h00, 5'd0, 5'd1, 5'd2, 32'h00000800, 1'b0, 32'h002090E3);
        vecs[9]  = mk("br_odd",    3'd4, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFD, 1'b1, 32'h0);
        vecs[10] = mk("kind5",     3'd5, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'd0,        1'b1, 32'h0);
        vecs[11] = mk("kind6",     3'd6, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'd0,        1'b1, 32'h0);

        rst_n = 1'b0; clear = 1'b0; reqValid = 1'b0; imemReady = 1'b0;
        drive(vecs[0]);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_we", 32'(imemWe), 32'd0);
        check("rst_addr", 32'(imemAddr), 32'd0);
        check("rst_data", imemWdata, 32'd0);
        check("rst_err", 32'(reqError), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(wordCount), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(reqReady), 32'd1);

        // Encoding table: each vector applied from a cleared state
        imemReady = 1'b1;
        for (int i = 0; i < 12; i++) begin
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            drive(vecs[i]);
            reqValid = 1'b1;
            @(negedge clk);
            reqValid = 1'b0;
            if (!vecs[i].expErr) begin
                check({vecs[i].name, "_we"}, 32'(imemWe), 32'd1);
                check({vecs[i].name, "_word"}, imemWdata, vecs[i].expWord);
                check({vecs[i].name, "_addr"}, 32'(imemAddr), 32'd0);
                check({vecs[i].name, "_rdy"}, 32'(reqReady), 32'd0);
                @(negedge clk);
                check({vecs[i].name, "_we_done"}, 32'(imemWe), 32'd0);
                check({vecs[i].name, "_cnt"}, 32'(wordCount), 32'd1);
                check({vecs[i].name, "_addr_inc"}, 32'(imemAddr), 32'd1);
            end else begin
                check({vecs[i].name, "_err"}, 32'(reqError), 32'd1);
                check({vecs[i].name, "_we"}, 32'(imemWe), 32'd0);
                check({vecs[i].name, "_rdy"}, 32'(reqReady), 32'd1);
                @(negedge clk);
                check({vecs[i].name, "_err_end"}, 32'(reqError), 32'd0);
                check({vecs[i].name, "_cnt"}, 32'(wordCount), 32'd0);
                check({vecs[i].name, "_we2"}, 32'(imemWe), 32'd0);
            end
        end

        // Back-to-back I / load / store at addresses 0..2
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(vecs[j == 0 ? 2 : (j == 1 ? 4 : 5)]);
            reqValid = 1'b1;
            @(negedge clk);
            reqValid = 1'b0;
            check("b2b_we", 32'(imemWe), 32'd1);
            check("b2b_addr", 32'(imemAddr), 32'(j));
            check("b2b_word", imemWdata, vecs[j == 0 ? 2 : (j == 1 ? 4 : 5)].expWord);
            check("b2b_rdy", 32'(reqReady), 32'd0);
            @(negedge clk);
        end
        check("b2b_cnt", 32'(wordCount), 32'd3);

        // Misaligned branch after writes: error, address unchanged
        drive(vecs[9]);
        reqValid = 1'b1;
        @(negedge clk);
        reqValid = 1'b0;
        check("brerr_pulse", 32'(reqError), 32'd1);
        check("brerr_we", 32'(imemWe), 32'd0);
        check("brerr_addr", 32'(imemAddr), 32'd3);
        @(negedge clk);
        check("brerr_end", 32'(reqError), 32'd0);
        check("brerr_cnt", 32'(wordCount), 32'd3);

        // Stall for 5 cycles; this fourth word fills the memory
        imemReady = 1'b0;
        drive(vecs[7]);
        reqValid = 1'b1;
        @(negedge clk);
        reqValid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall_we", 32'(imemWe), 32'd1);
            check("stall_addr", 32'(imemAddr), 32'd3);
            check("stall_word", imemWdata, 32'hFE208EE3);
            check("stall_rdy", 32'(reqReady), 32'd0);
            if (k < 4) @(negedge clk);
        end
        imemReady = 1'b1;
        @(negedge clk);
        check("full_we", 32'(imemWe), 32'd0);
        check("full_flag", 32'(full), 32'd1);
        check("full_cnt", 32'(wordCount), 32'd4);
        check("full_addr", 32'(imemAddr), 32'd0);
        check("full_rdy", 32'(reqReady), 32'd0);

        // Fifth request is refused while full
        drive(vecs[0]);
        reqValid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("full_norecv", 32'(imemWe), 32'd0);
        end

        // Clear with reqValid high: cleared, nothing accepted
        clear = 1'b1;
        @(negedge clk);
        check("clr_we", 32'(imemWe), 32'd0);
        check("clr_full", 32'(full), 32'd0);
        check("clr_cnt", 32'(wordCount), 32'd0);
        check("clr_rdy", 32'(reqReady), 32'd0);
        clear = 1'b0;
        reqValid = 1'b0;
        #1;
        check("clr_rdy_after", 32'(reqReady), 32'd1);

        // Clear during WRITE is ignored
        @(negedge clk);
        reqValid = 1'b1;
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        check("cw_cnt_pre", 32'(wordCount), 32'd1);
        imemReady = 1'b0;
        clear = 1'b1;
        drive(vecs[1]);
        reqValid = 1'b1;
        // clear=1 blocks acceptance in IDLE, so release it for the accept edge
        clear = 1'b0;
        @(negedge clk);
        reqValid = 1'b0;
        clear = 1'b1;
        repeat (2) @(negedge clk);
        check("cw_we", 32'(imemWe), 32'd1);
        check("cw_addr", 32'(imemAddr), 32'd1);
        clear = 1'b0;
        imemReady = 1'b1;
        @(negedge clk);
        check("cw_cnt", 32'(wordCount), 32'd2);
        check("cw_addr_inc", 32'(imemAddr), 32'd2);

        // Reset during a stalled WRITE
        imemReady = 1'b0;
        drive(vecs[4]);
        reqValid = 1'b1;
        @(negedge clk);
        reqValid = 1'b0;
        check("rw_we", 32'(imemWe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rw_we_drop", 32'(imemWe), 32'd0);
        check("rw_addr", 32'(imemAddr), 32'd0);
        check("rw_data", imemWdata, 32'd0);
        check("rw_cnt", 32'(wordCount), 32'd0);
        check("rw_full", 32'(full), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        imemReady = 1'b1;
        drive(vecs[5]);
        reqValid = 1'b1;
        @(negedge clk);
        reqValid = 1'b0;
        check("rw_new_we", 32'(imemWe), 32'd1);
        check("rw_new_addr", 32'(imemAddr), 32'd0);
        check("rw_new_word", imemWdata, 32'h0020A423);
        @(negedge clk);
        check("rw_new_cnt", 32'(wordCount), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction assembler that is the encoding counterpart of the `control` opcode decoder. It accepts field-level instruction requests (kind, registers, funct bits, immediate) over a valid/ready handshake and packs each into a 32-bit RV32I word with the correct opcode and immediate scatter. It streams the words into instruction memory at consecutive word addresses. It sits between a bench or boot sequencer and the imem write port, and is used to build programs for the single-cycle core.

## Interface
- ADDR_WIDTH, 10, imem word-address width; capacity is 2^ADDR_WIDTH words.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  when in IDLE, resets write address, wordCount and full; ignored in WRITE.
- reqValid  in  1  request valid.
- reqReady  out  1  request ready; combinational: IDLE & !full & !clear.
- reqKind  in  3  0=R-type (0110011), 1=I-ALU (0010011), 2=load (0000011), 3=store (0100011), 4=branch (1100011), 5-7 invalid.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field; R-type only.
- rd, rs1, rs2  in  5 each  register fields; unused fields are ignored per kind.
- imm  in  32  sign-extended immediate value; only the bits required by the kind are used.
- reqError  out  1  one-cycle pulse after an invalid request is accepted.
- imemWe  out  1  imem write enable.
- imemAddr  out  ADDR_WIDTH  imem word address.
- imemWdata  out  32  encoded instruction.
- imemReady  in  1  imem accepts the write on a cycle where imemWe=1.
- full  out  1  all 2^ADDR_WIDTH words have been written.
- wordCount  out  ADDR_WIDTH+1  number of words written since reset or clear.

## Operation
- FSM states: IDLE and WRITE.
- IDLE:
  - A request is accepted when reqValid & reqReady.
  - Valid request: register the encoded word into imemWdata, then go to WRITE.
  - Invalid request (reqKind 5-7, or reqKind=4 with imm[0]=1): stay in IDLE, pulse reqError, and write nothing.
- WRITE:
  - imemWe=1 and imemAddr and imemWdata are held stable.
  - On the edge where imemReady=1: imemAddr increments, wordCount increments, and the FSM returns to IDLE.
  - If wordCount reaches 2^ADDR_WIDTH, full is set and imemAddr wraps to 0.
- Encodings:
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  - I-ALU and load: imm[11:0] | rs1 | funct3 | rd | opcode.
  - Store: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
  - Branch: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
- Immediate bits above the used range are discarded without range checking.
- clear in IDLE: imemAddr=0, wordCount=0, full=0 on the next edge. No request is accepted in that cycle, because reqReady=0 while clear=1.
- Full: reqReady stays 0 until clear.

## Timing
- Reset values (asynchronous on rst_n=0):
  - state=IDLE, imemWe=0, imemAddr=0, imemWdata=0.
  - reqError=0, full=0, wordCount=0.
  - reqReady is 1 once out of reset if clear=0.
- Latency:
  - Request accepted at edge N; imemWe=1 with valid data from edge N to edge N+1.
  - With imemReady=1 the write completes at edge N+1.
  - The next request can be accepted at edge N+2, so peak throughput is 1 word per 2 cycles.
- imemReady low holds WRITE indefinitely with no change on any imem output.
- reqError is high for exactly the one cycle following acceptance. reqReady stays 1 across an error.
- Reset mid-WRITE: imemWe drops immediately, the in-flight word is lost, and the address returns to 0.
- clear asserted during WRITE has no effect. It must be held into IDLE to take effect.

## Test plan
- Reset, then R request (funct7=0, rs2=2, rs1=1, funct3=0, rd=3) with imemReady=1 -> imemWdata=0x002081B3 at addr 0 for one cycle; wordCount=1.
- Back-to-back requests:
  - I-ALU (rd=5, rs1=0, funct3=0, imm=-1) -> 0xFFF00293 at addr 0.
  - Load (rd=4, rs1=1, funct3=2, imm=4) -> 0x0040A203 at addr 1.
  - Store (rs2=2, rs1=1, funct3=2, imm=8) -> 0x0020A423 at addr 2.
  - reqReady low during each WRITE.
- Branch (rs1=1, rs2=2, funct3=0, imm=-4) -> 0xFE208EE3.
  - Repeat with imm=-3 -> reqError pulse, no imemWe, addr unchanged.
  - reqKind=6 -> reqError pulse, no write.
- imemReady held 0 for 5 cycles after acceptance -> imemWe, addr and data stable for all 5 cycles; completes on the first imemReady=1; reqReady=0 throughout.
- ADDR_WIDTH=2: write 4 words -> full=1, wordCount=4, imemAddr=0, reqReady=0.
  - A fifth reqValid is not accepted.
  - clear -> full=0, wordCount=0, and reqValid with clear=1 in the same cycle is not accepted.
- rst_n asserted while in WRITE with imemReady=0 -> imemWe=0 immediately and all outputs at their reset values; after release, a new request writes to addr 0.
